// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: default widths and
// the controller state encoding.
package div_pkg;

  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a down-counter that must hold the value n-1.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_row_8.sv
// One restoring-division row: compares the shifted-in partial remainder with the
// divisor and produces one quotient bit and the next partial remainder.
module div_row_8
  import div_pkg::*;
#(
  parameter int VW = VW_DEF
) (
  input  logic [VW:0]   t_i,
  input  logic [VW-1:0] d_i,
  output logic          q_bit_o,
  output logic [VW-1:0] rem_o
);

  logic [VW:0] diff_s;

  // Subtract when the divisor fits; R < y keeps the difference within VW bits.
  always_comb begin
    diff_s = t_i - {1'b0, d_i};
    if (t_i >= {1'b0, d_i}) begin
      q_bit_o = 1'b1;
      rem_o   = diff_s[VW-1:0];
    end else begin
      q_bit_o = 1'b0;
      rem_o   = t_i[VW-1:0];
    end
  end

endmodule

// File: rtl/iter_div_ctrl.sv
// Iterative unsigned divider controller: DW-bit dividend by VW-bit divisor,
// one quotient bit per cycle, with early exits for divide-by-zero and overflow.
module iter_div_ctrl
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x,
  input  logic [VW-1:0] y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] q,
  output logic [VW-1:0] r,
  output logic          dz,
  output logic          ovf
);

  localparam int CW = cnt_width(VW);

  state_e        state_q, state_d;
  logic [VW-1:0] r_q, r_d;
  logic [VW-1:0] s_q, s_d;
  logic [VW-1:0] q_q, q_d;
  logic [VW-1:0] y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;

  logic [VW-1:0] x_hi_s;
  logic [VW-1:0] x_lo_s;
  logic          div_zero_s;
  logic          quot_ovf_s;
  logic          row_q_bit_s;
  logic [VW-1:0] row_rem_s;

  assign x_hi_s     = x[DW-1:VW];
  assign x_lo_s     = x[VW-1:0];
  assign div_zero_s = (y == {VW{1'b0}});
  assign quot_ovf_s = !div_zero_s && (x_hi_s >= y);

  div_row_8 #(.VW(VW)) u_row (
    .t_i     ({r_q, s_q[VW-1]}),
    .d_i     (y_q),
    .q_bit_o (row_q_bit_s),
    .rem_o   (row_rem_s)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= {VW{1'b0}};
      s_q     <= {VW{1'b0}};
      q_q     <= {VW{1'b0}};
      y_q     <= {VW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      s_q     <= s_d;
      q_q     <= q_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (div_zero_s || quot_ovf_s) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: operand capture at accept, one restoring step per BUSY cycle.
  always_comb begin
    r_d   = r_q;
    s_d   = s_q;
    q_d   = q_q;
    y_d   = y_q;
    cnt_d = cnt_q;
    dz_d  = dz_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (div_zero_s) begin
            q_d   = {VW{1'b1}};
            r_d   = x_lo_s;
            dz_d  = 1'b1;
            ovf_d = 1'b0;
          end else if (quot_ovf_s) begin
            q_d   = {VW{1'b1}};
            r_d   = {VW{1'b0}};
            dz_d  = 1'b0;
            ovf_d = 1'b1;
          end else begin
            r_d   = x_hi_s;
            s_d   = x_lo_s;
            y_d   = y;
            q_d   = {VW{1'b0}};
            cnt_d = CW'(VW - 1);
            dz_d  = 1'b0;
            ovf_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      BUSY: begin
        r_d = row_rem_s;
        s_d = {s_q[VW-2:0], 1'b0};
        q_d = {q_q[VW-2:0], row_q_bit_s};
        if (cnt_q != {CW{1'b0}}) begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end
      DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = {CW{1'b0}};
      end
    endcase
  end

  // Handshake and result outputs, all derived directly from registers.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    q         = q_q;
    r         = r_q;
    dz        = dz_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_iter_div_ctrl.sv
// Self-checking bench for iter_div_ctrl: scoreboard of expected results pushed
// at accept and compared when out_valid appears.
module tb_iter_div_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        dz;
  logic        ovf;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ovf;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  iter_div_ctrl #(.DW(16), .VW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dz        (dz),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model; lat counts edges after the accept edge until DONE.
  function automatic exp_t model(input logic [15:0] xv, input logic [7:0] yv);
    exp_t e;
    if (yv == 8'd0) begin
      e.q = 8'hFF; e.r = xv[7:0]; e.dz = 1'b1; e.ovf = 1'b0; e.lat = 0;
    end else if ({8'd0, xv[15:8]} >= {8'd0, yv}) begin
      e.q = 8'hFF; e.r = 8'h00; e.dz = 1'b0; e.ovf = 1'b1; e.lat = 0;
    end else begin
      e.q = 8'(xv / {8'd0, yv}); e.r = 8'(xv % {8'd0, yv});
      e.dz = 1'b0; e.ovf = 1'b0; e.lat = 8;
    end
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = 16'h0; y = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (q !== 8'h00)        begin n_fail++; $display("FAIL reset_q got=%h exp=00", q); end
    n_cmp++; if (r !== 8'h00)        begin n_fail++; $display("FAIL reset_r got=%h exp=00", r); end
    n_cmp++; if (dz !== 1'b0)        begin n_fail++; $display("FAIL reset_dz got=%b exp=0", dz); end
    n_cmp++; if (ovf !== 1'b0)       begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst_n = 1'b1;
  endtask

  task automatic test_divide();
    logic [15:0] xs [8] = '{16'h1234, 16'h7FFF, 16'h03E8, 16'hABCD, 16'hFF00, 16'h00FF, 16'hFFFF, 16'h00FE};
    logic [7:0]  ys [8] = '{8'h56,    8'hFF,    8'h0A,    8'h00,    8'h80,    8'h01,    8'hFF,    8'hFF};
    exp_t e;
    int   lat;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL div_in_ready[%0d] got=%b exp=1", i, in_ready); end
      x = xs[i]; y = ys[i]; in_valid = 1'b1;
      sb.push_back(model(xs[i], ys[i]));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; x = ~xs[i]; y = ~ys[i];
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); @(negedge clk); lat++; end
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_fail++; $display("FAIL div_latency[%0d] got=%0d exp=%0d", i, lat, e.lat); end
      n_cmp++; if (q !== e.q)     begin n_fail++; $display("FAIL div_q[%0d] got=%h exp=%h", i, q, e.q); end
      n_cmp++; if (r !== e.r)     begin n_fail++; $display("FAIL div_r[%0d] got=%h exp=%h", i, r, e.r); end
      n_cmp++; if (dz !== e.dz)   begin n_fail++; $display("FAIL div_dz[%0d] got=%b exp=%b", i, dz, e.dz); end
      n_cmp++; if (ovf !== e.ovf) begin n_fail++; $display("FAIL div_ovf[%0d] got=%b exp=%b", i, ovf, e.ovf); end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL div_release_ov[%0d] got=%b exp=0", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL div_release_ir[%0d] got=%b exp=1", i, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    @(negedge clk);
    x = 16'h1234; y = 8'h56; in_valid = 1'b1;
    sb.push_back(model(16'h1234, 8'h56));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); @(negedge clk); lat++; end
    e = sb.pop_front();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got=%b exp=1", out_valid); end
    for (int k = 0; k < 5; k++) begin
      x = 16'h0001; y = 8'h01; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", k, out_valid); end
      n_cmp++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, in_ready); end
      n_cmp++; if ({q, r} !== {e.q, e.r}) begin n_fail++; $display("FAIL bp_qr[%0d] got=%h/%h exp=%h/%h", k, q, r, e.q, e.r); end
      n_cmp++; if ({dz, ovf} !== {e.dz, e.ovf}) begin n_fail++; $display("FAIL bp_flags[%0d] got=%b%b exp=%b%b", k, dz, ovf, e.dz, e.ovf); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_release_ir got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_ov got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_busy();
    exp_t e;
    int   lat;
    @(negedge clk);
    x = 16'h7FFF; y = 8'hFF; in_valid = 1'b1;
    sb.push_back(model(16'h7FFF, 8'hFF));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rb_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rb_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if ({q, r} !== 16'h0000) begin n_fail++; $display("FAIL rb_qr got=%h/%h exp=00/00", q, r); end
    x = 16'h03E8; y = 8'h0A; in_valid = 1'b1;
    sb.push_back(model(16'h03E8, 8'h0A));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); @(negedge clk); lat++; end
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_fail++; $display("FAIL rb_latency got=%0d exp=%0d", lat, e.lat); end
    n_cmp++; if ({q, r} !== {e.q, e.r}) begin n_fail++; $display("FAIL rb_qr_after got=%h/%h exp=%h/%h", q, r, e.q, e.r); end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          lat;
    logic [15:0] xv;
    logic [7:0]  yv;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      yv = (i % 5 == 4) ? 8'h00 : 8'($urandom_range(1, 255));
      xv = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      x = xv; y = yv; in_valid = 1'b1;
      sb.push_back(model(xv, yv));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; x = ~xv;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); @(negedge clk); lat++; end
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_fail++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, lat, e.lat); end
      n_cmp++; if ({q, r, dz, ovf} !== {e.q, e.r, e.dz, e.ovf}) begin
        n_fail++;
        $display("FAIL b2b_result[%0d] x=%h y=%h got=%h/%h/%b%b exp=%h/%h/%b%b", i, xv, yv, q, r, dz, ovf, e.q, e.r, e.dz, e.ovf);
      end
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready); end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_divide();
    test_backpressure();
    test_reset_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_div_ctrl.md
ITER_DIV_CTRL -- requirements
Module: iter_div_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16, meaning dividend width.
REQ-002 SHALL have parameter VW, default 8, meaning divisor/quotient/remainder width (DW = 2*VW).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  controller accepts operands (IDLE only).
REQ-007 SHALL have port x  input  DW  dividend, unsigned.
REQ-008 SHALL have port y  input  VW  divisor, unsigned.
REQ-009 SHALL have port out_valid  output  1  result held and valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port q  output  VW  quotient.
REQ-012 SHALL have port r  output  VW  remainder.
REQ-013 SHALL have port dz  output  1  divide-by-zero flag, qualified by out_valid.
REQ-014 SHALL have port ovf  output  1  quotient-overflow flag (x[DW-1:VW] >= y, y != 0), qualified by out_valid.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state == IDLE), out_valid = (state == DONE).
REQ-016 SHALL accept on edge where in_valid & in_ready; x, y captured into internal registers; later input changes ignored.
REQ-017 SHALL, at accept with y == 0, go directly to DONE with dz=1, ovf=0, q=all-ones, r=x[VW-1:0].
REQ-018 SHALL, at accept with y != 0 and x[DW-1:VW] >= y, go directly to DONE with ovf=1, dz=0, q=all-ones, r=0.
REQ-019 SHALL otherwise enter BUSY with partial remainder R = x[DW-1:VW], shift register S = x[VW-1:0], step counter = VW-1.
REQ-020 SHALL per BUSY edge form 9-bit T = {R, S[MSB]}; if T >= y: quotient bit 1, R = T - y; else quotient bit 0, R = T[VW-1:0]; S shifts left; quotient bit shifts into q LSB.
REQ-021 SHALL execute exactly VW BUSY steps (edges N+1..N+VW after accept edge N), entering DONE on edge N+VW with r = final R, dz=0, ovf=0.
REQ-022 SHALL invariant R < y in BUSY; result SHALL equal floor(x/y), x mod y.
REQ-023 SHALL hold q, r, dz, ovf stable while out_valid & !out_ready (unlimited backpressure).
REQ-024 SHALL return DONE -> IDLE on edge with out_ready high; in_ready rises the following cycle (no same-cycle re-accept).
REQ-025 SHALL ignore in_valid in BUSY and DONE; no abort input.

Reset
REQ-026 SHALL on rst_n low at a clock edge force IDLE regardless of state, including mid-BUSY; partial result discarded.
REQ-027 SHALL reset values: in_ready=1 after reset, out_valid=0, q=0, r=0, dz=0, ovf=0, counter=0.

Structure
REQ-028 SHALL place state enum (IDLE/BUSY/DONE) and DW/VW defaults in shared package div_pkg.
REQ-029 SHALL instantiate one combinational sub-module div_row_8 (one restoring row: 9-bit T, VW divisor -> q bit, VW remainder); FSM, counter, registers in iter_div_ctrl.

Verification
REQ-030 SHALL test x=0x1234, y=0x56 -> out_valid exactly 8 cycles after accept edge, q=0x36, r=0x10, dz=0, ovf=0.
REQ-031 SHALL test x=0x7FFF, y=0xFF -> q=0x80, r=0x7F; and x=0x03E8, y=0x0A -> q=0x64, r=0x00.
REQ-032 SHALL test y=0x00, x=0xABCD -> out_valid on cycle after accept, dz=1, q=0xFF, r=0xCD.
REQ-033 SHALL test x=0xFF00, y=0x80 -> out_valid on cycle after accept, ovf=1, q=0xFF, r=0x00.
REQ-034 SHALL test out_ready low 5 cycles in DONE -> q/r/flags stable, in_ready=0, in_valid ignored; out_ready high -> IDLE next cycle.
REQ-035 SHALL test rst_n low at 4th BUSY step -> next cycle IDLE, in_ready=1, out_valid=0, q=r=0; new division then completes correctly.
